game_tick_sync: RTL and testbench

GAME_TICK_SYNC -- requirements
Module: game_tick_sync

---
 rtl/game_tick_sync_if.sv | 14 +
 rtl/game_tick_sync.sv | 101 ++++++++++
 tb/tb_game_tick_sync.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/game_tick_sync_if.sv
// Game-tick bus: slow reference clock and enable in, tick strobe and lock status out.
interface game_tick_sync_if;
   localparam int unsigned CNT_W = 8;

   logic             slow_clk;
   logic             en;
   logic             tick;
   logic [CNT_W-1:0] tick_cnt;
   logic             locked;
   logic             lost;

   modport master (output slow_clk, en, input tick, tick_cnt, locked, lost);
   modport slave  (input slow_clk, en, output tick, tick_cnt, locked, lost);
endinterface

// File: rtl/game_tick_sync.sv
// Synchronizes a slow toggle clock into clk_in, tracks lock with a watchdog and
// emits a one-cycle game tick every TICK_DIV accepted rising edges.
module game_tick_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 25000,
   parameter int unsigned TICK_DIV    = 1
) (
   input  logic             clk_in,
   input  logic             rst,
   game_tick_sync_if.slave  bus
);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {ACQUIRE, LOCKED, LOST} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic                   tick_q, tick_d;
   logic [CNT_W-1:0]       cnt_q;
   logic                   locked_q, lost_q;
   logic                   rise_c;
   logic                   wd_full_c;

   assign rise_c    = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign wd_full_c = (wd_q == WD_W'(TIMEOUT));

   // State, synchronizer and registered outputs
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q  <= ACQUIRE;
         sync_q   <= '0;
         prev_q   <= 1'b0;
         wd_q     <= '0;
         div_q    <= '0;
         tick_q   <= 1'b0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.slow_clk};
         prev_q   <= sync_q[SYNC_STAGES-1];
         wd_q     <= wd_d;
         div_q    <= div_d;
         tick_q   <= tick_d;
         cnt_q    <= cnt_q + CNT_W'(tick_d);
         locked_q <= (state_d == LOCKED);
         lost_q   <= (state_d == LOST);
      end
   end

   // Next state; a rise always beats a simultaneous watchdog expiry
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tick_d  = 1'b0;
      if (rise_c)         wd_d = '0;
      else if (wd_full_c) wd_d = wd_q;
      else                wd_d = wd_q + WD_W'(1);

      case (state_q)
         ACQUIRE: begin
            if (rise_c) begin
               state_d = LOCKED;
               div_d   = '0;
            end
         end
         LOCKED: begin
            if (rise_c) begin
               if (bus.en) begin
                  if (div_q == DIV_W'(TICK_DIV - 1)) begin
                     tick_d = 1'b1;
                     div_d  = '0;
                  end else begin
                     div_d = div_q + DIV_W'(1);
                  end
               end
            end else if (wd_full_c) begin
               state_d = LOST;
            end
         end
         LOST: begin
            if (rise_c) begin
               state_d = LOCKED;
               div_d   = '0;
            end
         end
         default: state_d = ACQUIRE;
      endcase
   end

   assign bus.tick     = tick_q;
   assign bus.tick_cnt = cnt_q;
   assign bus.locked   = locked_q;
   assign bus.lost     = lost_q;
endmodule

// File: tb/tb_game_tick_sync.sv
// Bench for game_tick_sync: table-driven rise sequences with a tick scoreboard
// on a TICK_DIV=2 instance, plus a TICK_DIV=1 instance for counter wrap.
module tb_game_tick_sync;
   localparam int unsigned TO = 50;

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   exp_a  = 0;
   int   exp_b  = 0;
   logic ta_prev = 1'b0;
   logic tb_prev = 1'b0;

   typedef struct {int cyc; int cnt;} exp_t;
   exp_t q_a[$];
   exp_t q_b[$];

   typedef struct {logic en; bit tk; int hi; int lo;} vec_t;
   vec_t tbl[15];

   game_tick_sync_if ifa ();
   game_tick_sync_if ifb ();

   game_tick_sync #(.SYNC_STAGES(2), .TIMEOUT(TO), .TICK_DIV(2)) dut_a (
      .clk_in(clk_in), .rst(rst), .bus(ifa));
   game_tick_sync #(.SYNC_STAGES(2), .TIMEOUT(TO), .TICK_DIV(1)) dut_b (
      .clk_in(clk_in), .rst(rst), .bus(ifb));

   always #50 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Tick monitors: every tick must match the head of the scoreboard in cycle and count
   always @(negedge clk_in) begin
      if (rst) begin
         ta_prev <= 1'b0;
         tb_prev <= 1'b0;
      end else begin
         if (ifa.tick && ta_prev) chk("a_double_tick", 1, 0);
         if (ifb.tick && tb_prev) chk("b_double_tick", 1, 0);
         if (ifa.tick) begin
            chk("a_tick_expected", int'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
               chk("a_tick_cycle", cyc, q_a[0].cyc);
               chk("a_tick_cnt", int'(ifa.tick_cnt), q_a[0].cnt);
               q_a.delete(0);
            end
         end else if (q_a.size() != 0 && q_a[0].cyc < cyc) begin
            chk("a_tick_missing", cyc, q_a[0].cyc);
            q_a.delete(0);
         end
         if (ifb.tick) begin
            chk("b_tick_expected", int'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
               chk("b_tick_cycle", cyc, q_b[0].cyc);
               chk("b_tick_cnt", int'(ifb.tick_cnt), q_b[0].cnt);
               q_b.delete(0);
            end
         end else if (q_b.size() != 0 && q_b[0].cyc < cyc) begin
            chk("b_tick_missing", cyc, q_b[0].cyc);
            q_b.delete(0);
         end
         ta_prev <= ifa.tick;
         tb_prev <= ifb.tick;
      end
   end

   // Called at a negedge; slow_clk rises, E is the next posedge, lock checked at E+2
   task automatic rise_a(input logic en_v, input bit tk, input int hi, input int lo,
                         output int e);
      exp_t t;
      ifa.en       = en_v;
      ifa.slow_clk = 1'b1;
      e            = cyc + 1;
      if (tk) begin
         exp_a = (exp_a + 1) % 256;
         t.cyc = e + 2;
         t.cnt = exp_a;
         q_a.push_back(t);
      end
      repeat (3) @(negedge clk_in);
      chk("a_locked_after_rise", int'(ifa.locked), 1);
      chk("a_lost_after_rise", int'(ifa.lost), 0);
      repeat (hi - 3) @(negedge clk_in);
      ifa.slow_clk = 1'b0;
      repeat (lo) @(negedge clk_in);
   endtask

   task automatic rise_b(input bit tk);
      exp_t t;
      ifb.slow_clk = 1'b1;
      if (tk) begin
         exp_b = (exp_b + 1) % 256;
         t.cyc = cyc + 3;
         t.cnt = exp_b;
         q_b.push_back(t);
      end
      repeat (3) @(negedge clk_in);
      ifb.slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   initial begin
      int e;
      for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, (i == 2 || i == 4), 10, 10};
      for (int i = 5; i < 11; i++) tbl[i] = '{1'b0, 1'b0, 10, 10};
      tbl[11] = '{1'b1, 1'b0, 10, 10};
      tbl[12] = '{1'b1, 1'b1, 10, 10};
      tbl[13] = '{1'b1, 1'b0, 10, 41};
      tbl[14] = '{1'b1, 1'b1, 10, 0};

      ifa.slow_clk = 1'b0; ifa.en = 1'b1;
      ifb.slow_clk = 1'b0; ifb.en = 1'b1;
      e = 0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("rst_tick", int'(ifa.tick), 0);
      chk("rst_tick_cnt", int'(ifa.tick_cnt), 0);
      chk("rst_locked", int'(ifa.locked), 0);
      chk("rst_lost", int'(ifa.lost), 0);
      rst = 1'b0;

      // Rows 13/14 space the rises so the second detection lands on watchdog==TIMEOUT
      for (int i = 0; i < 15; i++) begin
         rise_a(tbl[i].en, tbl[i].tk, tbl[i].hi, tbl[i].lo, e);
         chk($sformatf("row%0d_tick_cnt", i), int'(ifa.tick_cnt), exp_a);
      end

      // Hold slow_clk low: LOST registers one cycle after watchdog hits TIMEOUT
      while (cyc < e + 52) @(negedge clk_in);
      chk("pre_lost_lost", int'(ifa.lost), 0);
      chk("pre_lost_locked", int'(ifa.locked), 1);
      @(negedge clk_in);
      chk("lost_lost", int'(ifa.lost), 1);
      chk("lost_locked", int'(ifa.locked), 0);
      repeat (5) @(negedge clk_in);

      rise_a(1'b1, 1'b0, 10, 10, e);
      for (int k = 0; k < 6; k++) rise_a(1'b1, (k % 2 == 1), 10, 10, e);
      chk("cnt_before_reset", int'(ifa.tick_cnt), 7);

      // Mid-period reset with slow_clk held high across release
      ifa.slow_clk = 1'b1;
      repeat (5) @(negedge clk_in);
      #10 rst = 1'b1;
      #1;
      chk("midrst_tick", int'(ifa.tick), 0);
      chk("midrst_tick_cnt", int'(ifa.tick_cnt), 0);
      chk("midrst_locked", int'(ifa.locked), 0);
      chk("midrst_lost", int'(ifa.lost), 0);
      exp_a = 0;
      @(negedge clk_in);
      rst = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("relock_locked", int'(ifa.locked), 1);
      chk("relock_tick_cnt", int'(ifa.tick_cnt), 0);
      repeat (7) @(negedge clk_in);
      ifa.slow_clk = 1'b0;
      repeat (10) @(negedge clk_in);
      rise_a(1'b1, 1'b0, 10, 10, e);
      rise_a(1'b1, 1'b1, 10, 10, e);

      // TICK_DIV=1 instance: lock, then 512 ticks across two counter wraps
      rise_b(1'b0);
      for (int k = 1; k <= 512; k++) begin
         rise_b(1'b1);
         if (k == 256) chk("b_cnt_after_256", int'(ifb.tick_cnt), 0);
         if (k == 257) chk("b_cnt_after_257", int'(ifb.tick_cnt), 1);
         if (k == 512) chk("b_cnt_after_512", int'(ifb.tick_cnt), 0);
      end

      repeat (5) @(negedge clk_in);
      chk("a_pending_ticks", q_a.size(), 0);
      chk("b_pending_ticks", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
